// File: rtl/water_tank_pkg.sv
// Shared types and sensor-select codes for the irrigation reservoir plant model.
package water_tank_pkg;

   localparam logic [1:0] SENSOR_LOW  = 2'd0;
   localparam logic [1:0] SENSOR_MID  = 2'd1;
   localparam logic [1:0] SENSOR_HIGH = 2'd2;
   localparam logic [1:0] SENSOR_NONE = 2'd3;

   typedef struct packed {
      logic supply;
      logic pump;
      logic dripper;
   } actuator_t;

   typedef struct packed {
      logic high;
      logic mid;
      logic low;
   } sensor_t;

endpackage

// File: rtl/water_tank_emulator_counter.sv
// Tank volume integrator: applies the net actuator delta on each tick, clamps to
// [0, CAPACITY] and pulses overflow/dry_run when the clamp bites.
module saturating_level_counter
   import water_tank_pkg::*;
#(
   parameter int LEVEL_WIDTH    = 8,
   parameter int CAPACITY       = 200,
   parameter int INIT_LEVEL     = 0,
   parameter int FILL_RATE      = 4,
   parameter int SPRINKLER_RATE = 3,
   parameter int DRIP_RATE      = 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   tick_i,
   input  actuator_t              act_i,
   output logic [LEVEL_WIDTH-1:0] level_o,
   output logic                   overflow_o,
   output logic                   dry_run_o
);

   // Two extra bits: one for sign, one for headroom above CAPACITY.
   localparam int SW = LEVEL_WIDTH + 2;
   localparam logic signed [SW-1:0] CAP_S   = SW'(CAPACITY);
   localparam logic signed [SW-1:0] FILL_S  = SW'(FILL_RATE);
   localparam logic signed [SW-1:0] SPRNK_S = SW'(SPRINKLER_RATE);
   localparam logic signed [SW-1:0] DRIP_S  = SW'(DRIP_RATE);

   logic signed [SW-1:0]   delta, sum;
   logic [LEVEL_WIDTH-1:0] level_q, level_d;
   logic                   ovf_q, ovf_d, dry_q, dry_d;

   always_comb begin
      delta = '0;
      if (act_i.supply)  delta = delta + FILL_S;
      if (act_i.pump)    delta = delta - SPRNK_S;
      if (act_i.dripper) delta = delta - DRIP_S;
      sum     = $signed({2'b00, level_q}) + delta;
      level_d = level_q;
      ovf_d   = 1'b0;
      dry_d   = 1'b0;
      if (tick_i) begin
         if (sum > CAP_S) begin
            level_d = LEVEL_WIDTH'(CAPACITY);
            ovf_d   = act_i.supply;
         end else if (sum[SW-1]) begin
            level_d = '0;
            dry_d   = act_i.pump | act_i.dripper;
         end else begin
            level_d = sum[LEVEL_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= LEVEL_WIDTH'(INIT_LEVEL);
         ovf_q   <= 1'b0;
         dry_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         ovf_q   <= ovf_d;
         dry_q   <= dry_d;
      end
   end

   assign level_o    = level_q;
   assign overflow_o = ovf_q;
   assign dry_run_o  = dry_q;

endmodule

// File: rtl/water_tank_emulator.sv
// Reservoir plant model: volume integrator plus registered level sensors with
// stuck-at fault injection for exercising the controller's conflict checks.
module water_tank_emulator
   import water_tank_pkg::*;
#(
   parameter int LEVEL_WIDTH    = 8,
   parameter int CAPACITY       = 200,
   parameter int INIT_LEVEL     = 0,
   parameter int LOW_THRESHOLD  = 20,
   parameter int MID_THRESHOLD  = 100,
   parameter int HIGH_THRESHOLD = 180,
   parameter int FILL_RATE      = 4,
   parameter int SPRINKLER_RATE = 3,
   parameter int DRIP_RATE      = 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   tick,
   input  logic                   supply_valve_open,
   input  logic                   splinker_bomb,
   input  logic                   dripper_valvule,
   input  logic                   fault_enable,
   input  logic [1:0]             fault_sensor,
   input  logic                   fault_value,
   output logic                   low_water_level,
   output logic                   mid_water_level,
   output logic                   high_water_level,
   output logic [LEVEL_WIDTH-1:0] level,
   output logic                   overflow,
   output logic                   dry_run
);

   if (!(LOW_THRESHOLD <= MID_THRESHOLD && MID_THRESHOLD <= HIGH_THRESHOLD &&
         HIGH_THRESHOLD <= CAPACITY && CAPACITY < (1 << LEVEL_WIDTH) &&
         INIT_LEVEL <= CAPACITY)) begin : g_bad_params
      $error("water_tank_emulator: thresholds must ascend and fit within CAPACITY");
   end

   localparam logic [LEVEL_WIDTH-1:0] LOW_T  = LEVEL_WIDTH'(LOW_THRESHOLD);
   localparam logic [LEVEL_WIDTH-1:0] MID_T  = LEVEL_WIDTH'(MID_THRESHOLD);
   localparam logic [LEVEL_WIDTH-1:0] HIGH_T = LEVEL_WIDTH'(HIGH_THRESHOLD);

   actuator_t              act;
   logic [LEVEL_WIDTH-1:0] level_cur;
   sensor_t                sens_q, sens_d;

   assign act = '{supply: supply_valve_open, pump: splinker_bomb, dripper: dripper_valvule};

   saturating_level_counter #(
      .LEVEL_WIDTH   (LEVEL_WIDTH),
      .CAPACITY      (CAPACITY),
      .INIT_LEVEL    (INIT_LEVEL),
      .FILL_RATE     (FILL_RATE),
      .SPRINKLER_RATE(SPRINKLER_RATE),
      .DRIP_RATE     (DRIP_RATE)
   ) u_counter (
      .clock     (clock),
      .reset_n   (reset_n),
      .tick_i    (tick),
      .act_i     (act),
      .level_o   (level_cur),
      .overflow_o(overflow),
      .dry_run_o (dry_run)
   );

   // Fault override sits after the comparators so contradictory patterns are possible.
   always_comb begin
      sens_d.low  = (level_cur >= LOW_T);
      sens_d.mid  = (level_cur >= MID_T);
      sens_d.high = (level_cur >= HIGH_T);
      if (fault_enable) begin
         case (fault_sensor)
            SENSOR_LOW:  sens_d.low  = fault_value;
            SENSOR_MID:  sens_d.mid  = fault_value;
            SENSOR_HIGH: sens_d.high = fault_value;
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sens_q <= '0;
      else          sens_q <= sens_d;
   end

   assign low_water_level  = sens_q.low;
   assign mid_water_level  = sens_q.mid;
   assign high_water_level = sens_q.high;
   assign level            = level_cur;

endmodule

// File: tb/tb_water_tank_emulator.sv
// Self-checking bench for water_tank_emulator: directed scenarios plus a
// randomized run against an integer-arithmetic model of the tank.
module tb_water_tank_emulator;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0, supply = 1'b0, pump = 1'b0, drip = 1'b0;
   logic       fe = 1'b0, fv = 1'b0;
   logic [1:0] fs = 2'd3;
   logic       low, mid, high, ovf, dry;
   logic [7:0] level;

   int n_pass = 0, n_total = 0;

   // Reference model state
   int         m_level = 0;
   logic [2:0] m_sens = 3'b000;   // {high, mid, low}
   logic       m_ovf = 1'b0, m_dry = 1'b0;

   always #5 clock = ~clock;

   water_tank_emulator dut (
      .clock(clock), .reset_n(reset_n), .tick(tick),
      .supply_valve_open(supply), .splinker_bomb(pump), .dripper_valvule(drip),
      .fault_enable(fe), .fault_sensor(fs), .fault_value(fv),
      .low_water_level(low), .mid_water_level(mid), .high_water_level(high),
      .level(level), .overflow(ovf), .dry_run(dry)
   );

   task automatic model_edge();
      int nv;
      logic [2:0] s;
      s[0] = (m_level >= 20);
      s[1] = (m_level >= 100);
      s[2] = (m_level >= 180);
      if (fe && fs != 2'd3) s[fs] = fv;
      m_sens = s;
      m_ovf = 1'b0;
      m_dry = 1'b0;
      if (tick) begin
         nv = m_level + 4 * int'(supply) - 3 * int'(pump) - int'(drip);
         if (supply && nv > 200) m_ovf = 1'b1;
         if ((pump || drip) && nv < 0) m_dry = 1'b1;
         if (nv > 200) nv = 200;
         if (nv < 0) nv = 0;
         m_level = nv;
      end
   endtask

   // Apply inputs, take one clock edge, leave time at edge+1 for sampling.
   task automatic cycle(input logic s, input logic p, input logic d, input logic t);
      supply = s; pump = p; drip = d; tick = t;
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      m_level = 0; m_sens = 3'b000; m_ovf = 1'b0; m_dry = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      n_total++;
      if ({level, low, mid, high, ovf, dry} !== 13'd0)
         $display("FAIL reset_state got level=%0d lmh=%b%b%b ovf=%b dry=%b want all 0", level, low, mid, high, ovf, dry);
      else n_pass++;
      do_reset();
      cycle(0, 0, 0, 0);
      n_total++;
      if (level !== 8'd0 || {low, mid, high} !== 3'b000)
         $display("FAIL reset_release got level=%0d lmh=%b%b%b want 0 000", level, low, mid, high);
      else n_pass++;
   endtask

   task automatic test_fill_low();
      do_reset();
      repeat (5) cycle(1, 0, 0, 1);
      n_total++;
      if (level !== 8'd20 || low !== 1'b0)
         $display("FAIL fill5_level got level=%0d low=%b want 20 0", level, low);
      else n_pass++;
      cycle(0, 0, 0, 0);
      n_total++;
      if ({low, mid, high} !== 3'b100)
         $display("FAIL fill5_sensors got lmh=%b%b%b want 100", low, mid, high);
      else n_pass++;
   endtask

   task automatic test_overflow();
      do_reset();
      repeat (50) cycle(1, 0, 0, 1);
      n_total++;
      if (level !== 8'd200 || ovf !== 1'b0)
         $display("FAIL fill50 got level=%0d ovf=%b want 200 0", level, ovf);
      else n_pass++;
      cycle(1, 0, 0, 1);
      n_total++;
      if (level !== 8'd200 || ovf !== 1'b1 || high !== 1'b1)
         $display("FAIL overflow_tick got level=%0d ovf=%b high=%b want 200 1 1", level, ovf, high);
      else n_pass++;
      cycle(1, 0, 0, 0);
      n_total++;
      if (ovf !== 1'b0 || level !== 8'd200)
         $display("FAIL overflow_pulse got ovf=%b level=%0d want 0 200", ovf, level);
      else n_pass++;
   endtask

   task automatic test_net_delta();
      do_reset();
      repeat (25) cycle(1, 0, 0, 1);
      repeat (10) cycle(1, 1, 1, 1);
      n_total++;
      if (level !== 8'd100)
         $display("FAIL net_zero got level=%0d want 100", level);
      else n_pass++;
      repeat (10) cycle(1, 1, 0, 1);
      n_total++;
      if (level !== 8'd110)
         $display("FAIL net_plus1 got level=%0d want 110", level);
      else n_pass++;
   endtask

   task automatic test_dry_run();
      logic [7:0] exp_lvl [3] = '{8'd1, 8'd0, 8'd0};
      logic       exp_dry [3] = '{1'b0, 1'b0, 1'b1};
      do_reset();
      cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 1, 1);
      n_total++;
      if (level !== 8'd2) $display("FAIL dry_setup got level=%0d want 2", level);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 1);
         n_total++;
         if (level !== exp_lvl[i] || dry !== exp_dry[i] || low !== 1'b0)
            $display("FAIL dry_step%0d got level=%0d dry=%b low=%b want %0d %b 0",
                     i, level, dry, low, exp_lvl[i], exp_dry[i]);
         else n_pass++;
      end
      cycle(0, 0, 0, 0);
      n_total++;
      if (dry !== 1'b0) $display("FAIL dry_pulse got dry=%b want 0", dry);
      else n_pass++;
   endtask

   task automatic test_fault();
      do_reset();
      repeat (13) cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 1, 1);
      fe = 1'b1; fs = 2'd2; fv = 1'b1;
      cycle(0, 0, 0, 0);
      n_total++;
      if (level !== 8'd50 || {low, mid, high} !== 3'b101)
         $display("FAIL fault_high got level=%0d lmh=%b%b%b want 50 101", level, low, mid, high);
      else n_pass++;
      fs = 2'd3;
      cycle(0, 0, 0, 0);
      n_total++;
      if ({low, mid, high} !== 3'b100)
         $display("FAIL fault_none got lmh=%b%b%b want 100", low, mid, high);
      else n_pass++;
      fs = 2'd0; fv = 1'b0;
      cycle(0, 0, 0, 0);
      n_total++;
      if ({low, mid, high} !== 3'b000)
         $display("FAIL fault_low got lmh=%b%b%b want 000", low, mid, high);
      else n_pass++;
      fe = 1'b0; fs = 2'd3;
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (38) cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 1, 1);
      cycle(0, 0, 0, 0);
      n_total++;
      if (level !== 8'd150 || {low, mid, high} !== 3'b110)
         $display("FAIL pre_reset got level=%0d lmh=%b%b%b want 150 110", level, low, mid, high);
      else n_pass++;
      cycle(1, 0, 0, 1);
      supply = 1'b1; tick = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      n_total++;
      if (level !== 8'd0 || {low, mid, high} !== 3'b000)
         $display("FAIL async_reset got level=%0d lmh=%b%b%b want 0 000", level, low, mid, high);
      else n_pass++;
      m_level = 0; m_sens = 3'b000; m_ovf = 1'b0; m_dry = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) cycle(1, 0, 0, 0);
      n_total++;
      if (level !== 8'd0 || ovf !== 1'b0)
         $display("FAIL hold_after_reset got level=%0d ovf=%b want 0 0", level, ovf);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs = 0;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         fe = ($urandom_range(0, 7) == 0);
         fs = 2'($urandom_range(0, 3));
         fv = 1'($urandom_range(0, 1));
         // Phase-biased drive so the level visits both rails.
         if ((i / 100) % 2 == 0)
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
         else
            cycle(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
         n_total++;
         if (int'(level) !== m_level || {high, mid, low} !== m_sens || ovf !== m_ovf || dry !== m_dry) begin
            if (errs < 10)
               $display("FAIL random_cyc%0d got level=%0d hml=%b ovf=%b dry=%b want %0d %b %b %b",
                        i, level, {high, mid, low}, ovf, dry, m_level, m_sens, m_ovf, m_dry);
            errs++;
         end else n_pass++;
      end
      fe = 1'b0; fs = 2'd3;
   endtask

   initial begin
      test_reset();
      test_fill_low();
      test_overflow();
      test_net_delta();
      test_dry_run();
      test_fault();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
